// File: rtl/fetch_unit.sv
// ============================================================================
// fetch_unit: owns the PC, issues one-at-a-time imem reads and presents a
// registered, stallable {instruction, pc} to decode. Rev 1.0
// ============================================================================
`default_nettype none

module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        stall,
  output logic        if_valid,
  output logic [31:0] if_instruction,
  output logic [31:0] if_pc,
  output logic [31:0] if_pc_plus4
);

  typedef enum logic [1:0] {
    S_RESET = 2'd0,
    S_REQ   = 2'd1,
    S_WAIT  = 2'd2,
    S_HOLD  = 2'd3
  } state_e;

  state_e      state_q;
  logic [31:0] pc_q;
  logic        kill_q;
  logic        valid_q;
  logic [31:0] instr_q;
  logic [31:0] out_pc_q;
  logic [31:0] out_pc4_q;
  logic [31:0] hold_instr_q;
  logic [31:0] hold_pc_q;

  logic [31:0] pc_inc_d;
  logic [31:0] hold_pc_inc_d;
  logic [31:0] redirect_pc_d;
  logic        redirect_lsb_unused;

  assign pc_inc_d            = pc_q + 32'd4;
  assign hold_pc_inc_d       = hold_pc_q + 32'd4;
  assign redirect_pc_d       = {redirect_pc[31:2], 2'b00};
  assign redirect_lsb_unused = ^redirect_pc[1:0];

  assign imem_req_valid = (state_q == S_REQ);
  assign imem_addr      = pc_q;
  assign if_valid       = valid_q;
  assign if_instruction = instr_q;
  assign if_pc          = out_pc_q;
  assign if_pc_plus4    = out_pc4_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_RESET;
      pc_q         <= RESET_PC;
      kill_q       <= 1'b0;
      valid_q      <= 1'b0;
      instr_q      <= 32'd0;
      out_pc_q     <= RESET_PC;
      out_pc4_q    <= RESET_PC + 32'd4;
      hold_instr_q <= 32'd0;
      hold_pc_q    <= RESET_PC;
    end else begin
      // Default: a live output taken by decode empties the register.
      if (valid_q && !stall) begin
        valid_q <= 1'b0;
      end

      if (redirect_valid) begin
        pc_q    <= redirect_pc_d;
        valid_q <= 1'b0;
        case (state_q)
          S_REQ: begin
            // An old-address request accepted this cycle must be discarded later.
            if (imem_req_ready) begin
              state_q <= S_WAIT;
              kill_q  <= 1'b1;
            end
          end
          S_WAIT: begin
            if (imem_rsp_valid) begin
              state_q <= S_REQ;
              kill_q  <= 1'b0;
            end else begin
              kill_q  <= 1'b1;
            end
          end
          default: begin
            state_q <= S_REQ;
            kill_q  <= 1'b0;
          end
        endcase
      end else begin
        case (state_q)
          S_RESET: begin
            state_q <= S_REQ;
          end
          S_REQ: begin
            if (imem_req_ready) begin
              state_q <= S_WAIT;
            end
          end
          S_WAIT: begin
            if (imem_rsp_valid) begin
              if (kill_q) begin
                kill_q  <= 1'b0;
                state_q <= S_REQ;
              end else if (!valid_q || !stall) begin
                valid_q   <= 1'b1;
                instr_q   <= imem_rsp_data;
                out_pc_q  <= pc_q;
                out_pc4_q <= pc_inc_d;
                pc_q      <= pc_inc_d;
                state_q   <= S_REQ;
              end else begin
                hold_instr_q <= imem_rsp_data;
                hold_pc_q    <= pc_q;
                pc_q         <= pc_inc_d;
                state_q      <= S_HOLD;
              end
            end
          end
          default: begin
            if (!stall) begin
              valid_q   <= 1'b1;
              instr_q   <= hold_instr_q;
              out_pc_q  <= hold_pc_q;
              out_pc4_q <= hold_pc_inc_d;
              state_q   <= S_REQ;
            end
          end
        endcase
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_fetch_unit.sv
// ============================================================================
// tb_fetch_unit: directed vector table, async-reset sequence and randomized
// run against an in-order instruction stream model. Rev 1.0
// ============================================================================
`default_nettype none

module tb_fetch_unit;

  logic        clk;
  logic        rst_n;
  logic        imem_req_valid, imem_req_ready, imem_rsp_valid;
  logic [31:0] imem_addr, imem_rsp_data;
  logic        redirect_valid, stall;
  logic [31:0] redirect_pc;
  logic        if_valid;
  logic [31:0] if_instruction, if_pc, if_pc_plus4;

  logic        w_req_valid, w_rsp_valid, w_if_valid;
  logic [31:0] w_addr, w_rsp_data, w_if_instruction, w_if_pc, w_if_pc_plus4;
  logic        w_acc;
  logic [31:0] w_acc_addr;

  fetch_unit #(.RESET_PC(32'h0000_0100)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_addr(imem_addr), .imem_rsp_valid(imem_rsp_valid),
    .imem_rsp_data(imem_rsp_data), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .stall(stall), .if_valid(if_valid),
    .if_instruction(if_instruction), .if_pc(if_pc), .if_pc_plus4(if_pc_plus4)
  );

  // Second instance starting at the top of the address space to see wrap.
  fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) dut_w (
    .clk(clk), .rst_n(rst_n),
    .imem_req_valid(w_req_valid), .imem_req_ready(1'b1),
    .imem_addr(w_addr), .imem_rsp_valid(w_rsp_valid),
    .imem_rsp_data(w_rsp_data), .redirect_valid(1'b0),
    .redirect_pc(32'd0), .stall(1'b0), .if_valid(w_if_valid),
    .if_instruction(w_if_instruction), .if_pc(w_if_pc), .if_pc_plus4(w_if_pc_plus4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  function automatic logic [31:0] memf(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // 1-cycle memory for the wrap instance, always ready.
  initial begin
    w_rsp_valid = 1'b0;
    w_rsp_data  = 32'd0;
    forever begin
      @(negedge clk);
      w_acc      = w_req_valid;
      w_acc_addr = w_addr;
      @(posedge clk);
      #1;
      w_rsp_valid = w_acc;
      w_rsp_data  = memf(w_acc_addr);
    end
  end

  // Memory model for the main instance (one pending slot, variable latency).
  bit          m_busy = 1'b0;
  logic [31:0] m_addr;
  int          m_cnt;
  int          lat_next = 1;

  // Reference stream: next PC decode must receive, in order.
  logic [31:0] exp_pc = 32'h100;
  int          n_cons = 0;

  logic        s_rst, s_req, s_rdy, s_ifv, s_redir, s_stall, s_w_ifv;
  logic [31:0] s_addr, s_ifpc, s_instr, s_p4, s_rpc, s_w_pc, s_w_p4, s_w_addr, s_w_instr;

  task automatic run_cycle();
    @(negedge clk);
    s_rst   = rst_n;     s_req   = imem_req_valid; s_rdy   = imem_req_ready;
    s_addr  = imem_addr; s_ifv   = if_valid;       s_ifpc  = if_pc;
    s_instr = if_instruction; s_p4 = if_pc_plus4;  s_redir = redirect_valid;
    s_rpc   = redirect_pc;    s_stall = stall;
    s_w_ifv = w_if_valid; s_w_pc = w_if_pc; s_w_p4 = w_if_pc_plus4;
    s_w_addr = w_addr;    s_w_instr = w_if_instruction;
    if (!s_rst) begin
      exp_pc = 32'h100;
    end else begin
      if (s_req) chk("addr_align", {30'd0, s_addr[1:0]}, 32'd0);
      if (s_ifv && !s_stall && !s_redir) begin
        chk("cons_pc", s_ifpc, exp_pc);
        chk("cons_instr", s_instr, memf(exp_pc));
        chk("cons_pc4", s_p4, exp_pc + 32'd4);
        exp_pc = exp_pc + 32'd4;
        n_cons++;
      end
      if (s_redir) exp_pc = {s_rpc[31:2], 2'b00};
    end
    @(posedge clk);
    #1;
    if (s_rst) begin
      if (s_redir) begin
        chk("flush_valid", {31'd0, if_valid}, 32'd0);
      end else if (s_ifv && s_stall) begin
        chk("stall_valid", {31'd0, if_valid}, 32'd1);
        chk("stall_pc", if_pc, s_ifpc);
        chk("stall_instr", if_instruction, s_instr);
      end
      if (s_req && !s_rdy && !s_redir) begin
        chk("req_hold_valid", {31'd0, imem_req_valid}, 32'd1);
        chk("req_hold_addr", imem_addr, s_addr);
      end
    end
    imem_rsp_valid = 1'b0;
    if (s_req && s_rdy) begin
      m_busy = 1'b1;
      m_addr = s_addr;
      m_cnt  = lat_next;
    end
    if (m_busy) begin
      m_cnt--;
      if (m_cnt <= 0) begin
        m_busy         = 1'b0;
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = memf(m_addr);
      end
    end
  endtask

  typedef struct {
    logic        stall;
    logic        redir;
    logic [31:0] rpc;
    int          lat;
    logic        req;
    logic [31:0] addr;
    logic        ifv;
    logic [31:0] ifpc;
  } vec_t;

  vec_t tbl [0:20];

  function automatic vec_t mk(input logic st, input logic rd, input logic [31:0] rp,
                              input int lt, input logic rq, input logic [31:0] ad,
                              input logic v, input logic [31:0] pc);
    vec_t r;
    r.stall = st; r.redir = rd; r.rpc = rp; r.lat = lt;
    r.req = rq;   r.addr = ad;  r.ifv = v;  r.ifpc = pc;
    return r;
  endfunction

  initial begin
    bit found;
    tbl[0]  = mk(0, 0, 0,        1, 0, 32'h100,  0, 32'h100);
    tbl[1]  = mk(0, 0, 0,        1, 1, 32'h100,  0, 32'h100);
    tbl[2]  = mk(0, 0, 0,        1, 0, 32'h100,  0, 32'h100);
    tbl[3]  = mk(0, 0, 0,        1, 1, 32'h104,  1, 32'h100);
    tbl[4]  = mk(0, 0, 0,        1, 0, 32'h104,  0, 32'h100);
    tbl[5]  = mk(1, 0, 0,        1, 1, 32'h108,  1, 32'h104);
    tbl[6]  = mk(1, 0, 0,        1, 0, 32'h108,  1, 32'h104);
    tbl[7]  = mk(1, 0, 0,        1, 0, 32'h10C,  1, 32'h104);
    tbl[8]  = mk(0, 0, 0,        1, 0, 32'h10C,  1, 32'h104);
    tbl[9]  = mk(0, 0, 0,        1, 1, 32'h10C,  1, 32'h108);
    tbl[10] = mk(0, 0, 0,        1, 0, 32'h10C,  0, 32'h108);
    tbl[11] = mk(0, 0, 0,        2, 1, 32'h110,  1, 32'h10C);
    tbl[12] = mk(0, 1, 32'h2000, 1, 0, 32'h110,  0, 32'h10C);
    tbl[13] = mk(0, 0, 0,        1, 0, 32'h2000, 0, 32'h10C);
    tbl[14] = mk(0, 0, 0,        1, 1, 32'h2000, 0, 32'h10C);
    tbl[15] = mk(0, 0, 0,        1, 0, 32'h2000, 0, 32'h10C);
    tbl[16] = mk(1, 1, 32'h3003, 1, 1, 32'h2004, 1, 32'h2000);
    tbl[17] = mk(0, 0, 0,        1, 0, 32'h3000, 0, 32'h2000);
    tbl[18] = mk(0, 0, 0,        1, 1, 32'h3000, 0, 32'h2000);
    tbl[19] = mk(0, 0, 0,        1, 0, 32'h3000, 0, 32'h2000);
    tbl[20] = mk(0, 0, 0,        1, 1, 32'h3004, 1, 32'h3000);

    imem_req_ready = 1'b1; imem_rsp_valid = 1'b0; imem_rsp_data = 32'd0;
    redirect_valid = 1'b0; redirect_pc = 32'd0;   stall = 1'b0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    chk("rst_req_valid", {31'd0, imem_req_valid}, 32'd0);
    chk("rst_addr", imem_addr, 32'h100);
    chk("rst_if_valid", {31'd0, if_valid}, 32'd0);
    chk("rst_instr", if_instruction, 32'd0);
    chk("rst_pc", if_pc, 32'h100);
    chk("rst_pc4", if_pc_plus4, 32'h104);
    chk("rst_wrap_pc4", w_if_pc_plus4, 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    for (int i = 0; i <= 20; i++) begin
      stall = tbl[i].stall; redirect_valid = tbl[i].redir;
      redirect_pc = tbl[i].rpc; lat_next = tbl[i].lat;
      run_cycle();
      chk($sformatf("v%0d_req", i), {31'd0, s_req}, {31'd0, tbl[i].req});
      chk($sformatf("v%0d_addr", i), s_addr, tbl[i].addr);
      chk($sformatf("v%0d_ifv", i), {31'd0, s_ifv}, {31'd0, tbl[i].ifv});
      if (tbl[i].ifv) begin
        chk($sformatf("v%0d_ifpc", i), s_ifpc, tbl[i].ifpc);
        chk($sformatf("v%0d_instr", i), s_instr, memf(tbl[i].ifpc));
      end
      if (i == 0) begin
        chk("wrap_rst_addr", s_w_addr, 32'hFFFF_FFFC);
        chk("wrap_rst_pc4", s_w_p4, 32'd0);
      end
      if (i == 3) begin
        chk("wrap_ifv", {31'd0, s_w_ifv}, 32'd1);
        chk("wrap_pc", s_w_pc, 32'hFFFF_FFFC);
        chk("wrap_pc4", s_w_p4, 32'd0);
        chk("wrap_next_addr", s_w_addr, 32'd0);
        chk("wrap_instr", s_w_instr, memf(32'hFFFF_FFFC));
      end
    end

    // Asynchronous reset while a slow response is outstanding.
    stall = 1'b0; redirect_valid = 1'b0; imem_req_ready = 1'b1; lat_next = 3;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      run_cycle();
      if (s_req && s_rdy) found = 1'b1;
    end
    chk("arst_accept_seen", {31'd0, found}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_req_valid", {31'd0, imem_req_valid}, 32'd0);
    chk("arst_addr", imem_addr, 32'h100);
    chk("arst_if_valid", {31'd0, if_valid}, 32'd0);
    chk("arst_instr", if_instruction, 32'd0);
    chk("arst_pc", if_pc, 32'h100);
    chk("arst_pc4", if_pc_plus4, 32'h104);
    lat_next = 1;
    run_cycle();
    #2 rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      run_cycle();
      chk($sformatf("arst_late_rsp_ifv%0d", i), {31'd0, s_ifv}, 32'd0);
    end
    run_cycle();
    chk("arst_restart_ifv", {31'd0, s_ifv}, 32'd1);
    chk("arst_restart_pc", s_ifpc, 32'h100);

    // Randomized traffic against the in-order stream model.
    for (int i = 0; i < 1500; i++) begin
      imem_req_ready = ($urandom_range(3) != 0);
      stall          = ($urandom_range(2) == 0);
      redirect_valid = ($urandom_range(15) == 0);
      redirect_pc    = ($urandom_range(3) == 0) ? (32'hFFFF_FFF4 + $urandom_range(11)) : $urandom;
      lat_next       = $urandom_range(3, 1);
      run_cycle();
    end
    chk("progress", {31'd0, (n_cons >= 80)}, 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
